// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the traffic controller and its passive monitor.
// The master modport drives the lamp vector and control; the slave modport is the monitor.
interface traffic_light_monitor_if #(
    parameter int DW = 8
);
    logic          en;
    logic [3:0]    lamps;
    logic          clr_err;
    logic          locked;
    logic          err;
    logic [2:0]    err_code;
    logic [DW-1:0] dwell;
    logic [15:0]   phase_cnt;

    modport master (
        output en, lamps, clr_err,
        input  locked, err, err_code, dwell, phase_cnt
    );

    modport slave (
        input  en, lamps, clr_err,
        output locked, err, err_code, dwell, phase_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker of lamp phase order and dwell timing, with sticky first-error capture.
// Define TLM_WDOG_EN to add the green-phase watchdog (error code 5 once dwell passes GMAX).
module traffic_light_monitor #(
    parameter int GMIN = 4,
    parameter int YLEN = 2,
    parameter int DW   = 8
`ifdef TLM_WDOG_EN
    ,
    parameter int GMAX = 32
`endif
) (
    input  logic                  clk,
    input  logic                  res_n,
    traffic_light_monitor_if.slave bus
);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    localparam logic [DW-1:0] GMIN_D = DW'(GMIN);
    localparam logic [DW-1:0] YLEN_D = DW'(YLEN);

    state_t        r_state;
    logic          r_locked;
    logic          r_err;
    logic [2:0]    r_errCode;
    logic [DW-1:0] r_dwell;
    logic [15:0]   r_phaseCnt;
    logic [3:0]    r_lampsQ;

    logic          w_oneHot;
    logic          w_change;
    logic          w_legalNext;
    logic          w_oldGreen;
    logic          w_wdogHit;
    logic [DW-1:0] w_dwellInc;
    logic [2:0]    w_newErr;

    assign w_oneHot    = (bus.lamps == 4'b0001) || (bus.lamps == 4'b0010) ||
                         (bus.lamps == 4'b0100) || (bus.lamps == 4'b1000);
    assign w_change    = (bus.lamps != r_lampsQ);
    // The legal sequence is a left rotation of the one-hot phase vector.
    assign w_legalNext = (bus.lamps == {r_lampsQ[2:0], r_lampsQ[3]});
    assign w_oldGreen  = r_lampsQ[0] | r_lampsQ[2];
    assign w_dwellInc  = (&r_dwell) ? r_dwell : r_dwell + 1'b1;

`ifdef TLM_WDOG_EN
    localparam logic [DW-1:0] GMAX_D = DW'(GMAX);
    // Fires on the edge dwell steps from GMAX to GMAX+1, so only once per green phase.
    assign w_wdogHit = (r_state == TRACK) && !w_change && w_oldGreen && (r_dwell == GMAX_D);
`else
    assign w_wdogHit = 1'b0;
`endif

    always_comb begin
        w_newErr = 3'd0;
        if (bus.en) begin
            if (r_state == IDLE) begin
                if ((bus.lamps != 4'b0000) && !w_oneHot) begin
                    w_newErr = 3'd1;
                end
            end else if (w_change) begin
                if (!w_oneHot) begin
                    w_newErr = 3'd1;
                end else if (!w_legalNext) begin
                    w_newErr = 3'd2;
                end else if (w_oldGreen && (r_dwell < GMIN_D)) begin
                    w_newErr = 3'd3;
                end else if (!w_oldGreen && (r_dwell != YLEN_D)) begin
                    w_newErr = 3'd4;
                end
            end else if (w_wdogHit) begin
                w_newErr = 3'd5;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_errCode  <= 3'd0;
            r_dwell    <= '0;
            r_phaseCnt <= 16'd0;
            r_lampsQ   <= 4'b0000;
        end else begin
            if (!bus.en) begin
                r_state  <= IDLE;
                r_locked <= 1'b0;
                r_dwell  <= '0;
                r_lampsQ <= 4'b0000;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_oneHot) begin
                            r_state  <= TRACK;
                            r_locked <= 1'b1;
                            r_lampsQ <= bus.lamps;
                            r_dwell  <= DW'(1);
                        end
                    end
                    TRACK: begin
                        if (!w_change) begin
                            r_dwell <= w_dwellInc;
                        end else if (w_oneHot && w_legalNext) begin
                            r_lampsQ   <= bus.lamps;
                            r_dwell    <= DW'(1);
                            r_phaseCnt <= r_phaseCnt + 16'd1;
                        end else begin
                            r_state  <= IDLE;
                            r_locked <= 1'b0;
                            r_dwell  <= '0;
                            r_lampsQ <= 4'b0000;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end

            // A clear on the same edge as a new error yields the new error.
            if (bus.clr_err) begin
                r_err     <= (w_newErr != 3'd0);
                r_errCode <= w_newErr;
            end else if ((w_newErr != 3'd0) && !r_err) begin
                r_err     <= 1'b1;
                r_errCode <= w_newErr;
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err       = r_err;
    assign bus.err_code  = r_errCode;
    assign bus.dwell     = r_dwell;
    assign bus.phase_cnt = r_phaseCnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: vector table plus hand-written
// sequences, with expected outputs queued at drive time and compared after each edge.
module tb_traffic_light_monitor;

    typedef struct {
        logic        en;
        logic [3:0]  lamps;
        logic        clr;
        logic        locked;
        logic        err;
        logic [2:0]  code;
        logic [7:0]  dwell;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        locked;
        logic        err;
        logic [2:0]  code;
        logic [7:0]  dwell;
        logic [15:0] cnt;
    } exp_t;

`ifdef TLM_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif

    logic clk;
    logic res_n;
    int   checks;
    int   errors;
    vec_t vecs[$];
    exp_t sbQ[$];

    traffic_light_monitor_if #(.DW(8)) bus ();

    traffic_light_monitor dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic addVec(input logic en, input logic [3:0] lamps, input logic clr,
                          input logic locked, input logic err, input logic [2:0] code,
                          input logic [7:0] dwell, input logic [15:0] cnt);
        vec_t v;
        v.en = en; v.lamps = lamps; v.clr = clr;
        v.locked = locked; v.err = err; v.code = code; v.dwell = dwell; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got empty scoreboard expected queued result", name);
        end else begin
            e = sbQ.pop_front();
            compareField(name, "locked",    16'(bus.locked),    16'(e.locked));
            compareField(name, "err",       16'(bus.err),       16'(e.err));
            compareField(name, "err_code",  16'(bus.err_code),  16'(e.code));
            compareField(name, "dwell",     16'(bus.dwell),     16'(e.dwell));
            compareField(name, "phase_cnt", bus.phase_cnt,      e.cnt);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        bus.en      = v.en;
        bus.lamps   = v.lamps;
        bus.clr_err = v.clr;
        e.locked = v.locked; e.err = v.err; e.code = v.code; e.dwell = v.dwell; e.cnt = v.cnt;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    task automatic pushZero();
        exp_t e;
        e.locked = 1'b0; e.err = 1'b0; e.code = 3'd0; e.dwell = 8'd0; e.cnt = 16'd0;
        sbQ.push_back(e);
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        res_n       = 1'b0;
        bus.en      = 1'b0;
        bus.lamps   = 4'b0000;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pushZero();
        checkOutput(name);
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        checks      = 0;
        errors      = 0;
        res_n       = 1'b0;
        bus.en      = 1'b0;
        bus.lamps   = 4'b0000;
        bus.clr_err = 1'b0;

        // Legal full cycle
        addVec(1, 4'b0001, 0, 1, 0, 0, 1, 0);
        addVec(1, 4'b0001, 0, 1, 0, 0, 2, 0);
        addVec(1, 4'b0001, 0, 1, 0, 0, 3, 0);
        addVec(1, 4'b0001, 0, 1, 0, 0, 4, 0);
        addVec(1, 4'b0010, 0, 1, 0, 0, 1, 1);
        addVec(1, 4'b0010, 0, 1, 0, 0, 2, 1);
        addVec(1, 4'b0100, 0, 1, 0, 0, 1, 2);
        addVec(1, 4'b0100, 0, 1, 0, 0, 2, 2);
        addVec(1, 4'b0100, 0, 1, 0, 0, 3, 2);
        addVec(1, 4'b0100, 0, 1, 0, 0, 4, 2);
        addVec(1, 4'b1000, 0, 1, 0, 0, 1, 3);
        addVec(1, 4'b1000, 0, 1, 0, 0, 2, 3);
        addVec(1, 4'b0001, 0, 1, 0, 0, 1, 4);
        // Illegal order: green straight to EW green
        addVec(1, 4'b0001, 0, 1, 0, 0, 2, 4);
        addVec(1, 4'b0001, 0, 1, 0, 0, 3, 4);
        addVec(1, 4'b0001, 0, 1, 0, 0, 4, 4);
        addVec(1, 4'b0100, 0, 0, 1, 2, 0, 4);
        addVec(1, 4'b0000, 1, 0, 0, 0, 0, 4);
        // Short green, then bad yellow length: first error wins
        addVec(1, 4'b0001, 0, 1, 0, 0, 1, 4);
        addVec(1, 4'b0001, 0, 1, 0, 0, 2, 4);
        addVec(1, 4'b0001, 0, 1, 0, 0, 3, 4);
        addVec(1, 4'b0010, 0, 1, 1, 3, 1, 5);
        addVec(1, 4'b0010, 0, 1, 1, 3, 2, 5);
        addVec(1, 4'b0010, 0, 1, 1, 3, 3, 5);
        addVec(1, 4'b0100, 0, 1, 1, 3, 1, 6);
        // Encoding errors and clear behaviour
        addVec(1, 4'b0100, 1, 1, 0, 0, 2, 6);
        addVec(1, 4'b0000, 0, 0, 1, 1, 0, 6);
        addVec(1, 4'b0000, 1, 0, 0, 0, 0, 6);
        addVec(1, 4'b0011, 0, 0, 1, 1, 0, 6);
        addVec(1, 4'b0000, 0, 0, 1, 1, 0, 6);
        addVec(1, 4'b0011, 1, 0, 1, 1, 0, 6);
        addVec(1, 4'b0000, 1, 0, 0, 0, 0, 6);
        // Enable dropped mid-green, then restart
        addVec(1, 4'b0001, 0, 1, 0, 0, 1, 6);
        addVec(1, 4'b0001, 0, 1, 0, 0, 2, 6);
        addVec(0, 4'b0001, 0, 0, 0, 0, 0, 6);
        addVec(0, 4'b0011, 0, 0, 0, 0, 0, 6);
        addVec(1, 4'b0001, 0, 1, 0, 0, 1, 6);

        doReset("reset");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Yellow held until dwell saturates, then a legal change flags code 4
        for (int k = 2; k <= 4; k++) begin
            v = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 3'd0, 8'(k), 16'd6};
            applyStimulus(v, $sformatf("satGreen%0d", k));
        end
        for (int k = 1; k <= 300; k++) begin
            v = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 3'd0, 8'((k > 255) ? 255 : k), 16'd7};
            applyStimulus(v, $sformatf("satYellow%0d", k));
        end
        v = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 3'd4, 8'd1, 16'd8};
        applyStimulus(v, "satExit");

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        res_n = 1'b0;
        #1;
        pushZero();
        checkOutput("asyncReset");
        @(negedge clk);
        res_n = 1'b1;

        // Long green: watchdog code 5 at dwell 33 only when built in
        doReset("wdogReset");
        for (int k = 1; k <= 40; k++) begin
            v = '{1'b1, 4'b0001, 1'b0, 1'b1, (WdogOn && k >= 33), ((WdogOn && k >= 33) ? 3'd5 : 3'd0),
                  8'(k), 16'd0};
            applyStimulus(v, $sformatf("wdog%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
